// File: rtl/genius_sequence_player.sv
// Genius colour-sequence player: replays a seeded LFSR sequence on one-hot LEDs paced by a divided clock.
// Optional feature macro GENIUS_PLAYER_ABORT_EN adds abort_i, which cancels a play without a done pulse.
module genius_sequence_player #(
  parameter int unsigned MAX_LEN = 32,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_1_i,
  input  logic       clk_2_i,
  input  logic       clk_3_i,
  input  logic       clk_5_i,
  input  logic [1:0] speed_i,
  input  logic       start_i,
  input  logic [5:0] len_i,
`ifdef GENIUS_PLAYER_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] led_o,
  output logic [5:0] step_o,
  output logic [1:0] color_o
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ON, S_OFF, S_DONE} state_t;

  localparam logic [5:0] MaxLen6 = 6'(MAX_LEN);

  state_t     r_state;
  logic [1:0] r_speed;
  logic [5:0] r_len;
  logic [5:0] r_step;
  logic [7:0] r_lfsr;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_led;
  logic [1:0] r_color;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_edge;

  logic [1:0] w_speed;
  logic       w_div;
  logic       w_tick;
  logic       w_abort;
  logic [7:0] w_lfsr_next;
  logic [5:0] w_len_clamped;

`ifdef GENIUS_PLAYER_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // While idle the synchroniser already follows speed_i, so the latched choice causes no source switch at start.
  assign w_speed = (r_state == S_IDLE) ? speed_i : r_speed;

  always_comb begin
    w_div = clk_1_i;
    case (w_speed)
      2'd0:    w_div = clk_1_i;
      2'd1:    w_div = clk_2_i;
      2'd2:    w_div = clk_3_i;
      default: w_div = clk_5_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= w_div;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  // Both edges of the synchronised wave tick, giving one tick per half-period.
  assign w_tick = r_sync2 ^ r_edge;

  assign w_lfsr_next   = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_len_clamped = ({26'd0, len_i} > MAX_LEN) ? MaxLen6 : len_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_speed <= 2'd0;
      r_len   <= 6'd0;
      r_step  <= 6'd0;
      r_lfsr  <= SEED;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_led   <= 4'd0;
      r_color <= 2'd0;
    end else begin
      r_done <= 1'b0;
      if (w_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_led   <= 4'd0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i && !w_abort) begin
              r_speed <= speed_i;
              r_len   <= w_len_clamped;
              r_lfsr  <= SEED;
              r_step  <= 6'd0;
              r_busy  <= 1'b1;
              if (w_len_clamped == 6'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_ALIGN;
              end
            end
          end
          S_ALIGN: begin
            if (w_tick) begin
              r_state <= S_ON;
              r_led   <= 4'b0001 << r_lfsr[1:0];
              r_color <= r_lfsr[1:0];
            end
          end
          S_ON: begin
            if (w_tick) begin
              r_state <= S_OFF;
              r_led   <= 4'd0;
              r_step  <= r_step + 6'd1;
              r_lfsr  <= w_lfsr_next;
            end
          end
          S_OFF: begin
            if (w_tick) begin
              if (r_step == r_len) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_ON;
                r_led   <= 4'b0001 << r_lfsr[1:0];
                r_color <= r_lfsr[1:0];
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_led   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign led_o   = r_led;
  assign step_o  = r_step;
  assign color_o = r_color;

endmodule

// File: tb/tb_genius_sequence_player.sv
// Bench for genius_sequence_player: a step-level model checks every cycle, directed plays pin the sequence.
// Define GENIUS_PLAYER_ABORT_EN to also exercise the abort input.
module tb_genius_sequence_player;

  logic       clk;
  logic       rst;
  logic       clk1;
  logic       clk2;
  logic       clk3;
  logic       clk5;
  logic [1:0] speed;
  logic       start;
  logic [5:0] len;
`ifdef GENIUS_PLAYER_ABORT_EN
  logic       abort;
`endif
  logic       busy_o;
  logic       done_o;
  logic [3:0] led_o;
  logic [5:0] step_o;
  logic [1:0] color_o;

  int vectors = 0;
  int miscompares = 0;
  int doneCount = 0;
  int expLen = 0;
  int expHalf = 10;

  logic [3:0] pulses[$];
  logic [3:0] prevLed;
  logic       prevBusy;
  logic       prevDone;
  logic       seenFall;
  int         onRun;
  int         offRun;

  genius_sequence_player dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clk_1_i (clk1),
    .clk_2_i (clk2),
    .clk_3_i (clk3),
    .clk_5_i (clk5),
    .speed_i (speed),
    .start_i (start),
    .len_i   (len),
`ifdef GENIUS_PLAYER_ABORT_EN
    .abort_i (abort),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .led_o   (led_o),
    .step_o  (step_o),
    .color_o (color_o)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  // Divided clocks in simulation scale: half-periods of 50, 25, 16 and 10 system cycles.
  initial begin clk1 = 0; #3; forever #500 clk1 = ~clk1; end
  initial begin clk2 = 0; #3; forever #250 clk2 = ~clk2; end
  initial begin clk3 = 0; #3; forever #160 clk3 = ~clk3; end
  initial begin clk5 = 0; #3; forever #100 clk5 = ~clk5; end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Colour after k completed steps, stepping the seed with the tap mask for bits 7,5,4,3.
  function automatic logic [1:0] expColor(input int k);
    logic [7:0] q;
    q = 8'hA5;
    for (int i = 0; i < k; i++) q = {q[6:0], ^(q & 8'b1011_1000)};
    return q[1:0];
  endfunction

  function automatic int halfOf(input logic [1:0] s);
    case (s)
      2'd0:    return 50;
      2'd1:    return 25;
      2'd2:    return 16;
      default: return 10;
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] s, input logic [5:0] l);
    speed   = s;
    len     = l;
    expLen  = (l > 6'd32) ? 32 : int'(l);
    expHalf = halfOf(s);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitLit(input logic [5:0] stepWanted, input int budget);
    int n;
    n = 0;
    while (!(step_o == stepWanted && led_o != 4'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(step_o == stepWanted && led_o != 4'd0)) checkOutput("litTimeout", 32'd0, 32'd1);
  endtask

  // Every-cycle compare against the step-level model: colour per step, on/off durations, done rules.
  always @(negedge clk) begin
    if (rst) begin
      prevLed  = 4'd0;
      prevBusy = 1'b0;
      prevDone = 1'b0;
      seenFall = 1'b0;
      onRun    = 0;
      offRun   = 0;
    end else begin
      if (busy_o && !prevBusy) begin
        pulses.delete();
        seenFall = 1'b0;
        offRun   = 0;
      end
      if (led_o != 4'd0) begin
        if (prevLed == 4'd0) begin
          if (seenFall) checkOutput("offTime", offRun, expHalf);
          pulses.push_back(led_o);
          onRun = 0;
        end
        onRun++;
        checkOutput("ledModel", led_o, 4'b0001 << expColor(int'(step_o)));
        checkOutput("colorModel", color_o, expColor(int'(step_o)));
        checkOutput("stepIndex", step_o, pulses.size() - 1);
        checkOutput("busyLit", busy_o, 1);
      end else begin
        if (prevLed != 4'd0) begin
          checkOutput("onTime", onRun, expHalf);
          seenFall = 1'b1;
          offRun   = 0;
        end
        if (done_o && seenFall) checkOutput("offTime", offRun, expHalf);
        offRun++;
      end
      if (done_o) begin
        doneCount++;
        checkOutput("doneStep", step_o, expLen);
        checkOutput("donePulses", pulses.size(), expLen);
        checkOutput("doneBusy", busy_o, 1);
        checkOutput("doneWidth", prevDone, 0);
      end
      if (prevDone && !done_o) checkOutput("busyFall", busy_o, 0);
      if (busy_o) checkOutput("stepBound", step_o <= expLen, 1);
      prevLed  = led_o;
      prevBusy = busy_o;
      prevDone = done_o;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] expA[4];
    logic [3:0] firstA;
    logic [3:0] firstB;
    int dc;
    expA = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    rst = 1'b1; start = 1'b0; speed = 2'd0; len = 6'd0;
`ifdef GENIUS_PLAYER_ABORT_EN
    abort = 1'b0;
`endif
    #7;
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstDone", done_o, 0);
    checkOutput("rstLed", led_o, 0);
    checkOutput("rstStep", step_o, 0);
    checkOutput("rstColor", color_o, 0);
    #20;
    @(negedge clk) rst = 1'b0;

    $display("[TB] speed 3, len 4");
    applyStimulus(2'd3, 6'd4);
    waitDone(400);
    repeat (3) @(negedge clk);
    checkOutput("seqCount", pulses.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("seqLed", (i < pulses.size()) ? pulses[i] : 4'hF, expA[i]);
    checkOutput("doneOnce", doneCount, 1);
    checkOutput("idleBusy", busy_o, 0);

    $display("[TB] seed reload");
    applyStimulus(2'd3, 6'd1);
    waitDone(400);
    repeat (2) @(negedge clk);
    firstA = (pulses.size() > 0) ? pulses[0] : 4'hF;
    applyStimulus(2'd3, 6'd2);
    waitDone(400);
    repeat (2) @(negedge clk);
    firstB = (pulses.size() > 0) ? pulses[0] : 4'hE;
    checkOutput("reloadSame", firstB, firstA);
    checkOutput("reloadFirst", firstA, 4'b0010);
    checkOutput("reloadSecond", (pulses.size() > 1) ? pulses[1] : 4'hF, 4'b0100);

    $display("[TB] len 0");
    dc = doneCount;
    applyStimulus(2'd3, 6'd0);
    checkOutput("zeroDone", done_o, 1);
    checkOutput("zeroBusy", busy_o, 1);
    checkOutput("zeroLed", led_o, 0);
    @(posedge clk); #1;
    checkOutput("zeroDoneLow", done_o, 0);
    checkOutput("zeroBusyLow", busy_o, 0);
    repeat (20) @(negedge clk);
    checkOutput("zeroPulses", pulses.size(), 0);
    checkOutput("zeroDoneCount", doneCount, dc + 1);

    $display("[TB] other speeds");
    applyStimulus(2'd2, 6'd2);
    waitDone(400);
    repeat (2) @(negedge clk);
    checkOutput("spd2Count", pulses.size(), 2);
    applyStimulus(2'd0, 6'd1);
    waitDone(400);
    repeat (2) @(negedge clk);
    checkOutput("spd0Count", pulses.size(), 1);
    applyStimulus(2'd1, 6'd1);
    waitDone(400);
    repeat (2) @(negedge clk);
    checkOutput("spd1Count", pulses.size(), 1);

    $display("[TB] len 40 clamp with ignored start");
    dc = doneCount;
    applyStimulus(2'd3, 6'd40);
    repeat (100) @(posedge clk);
    #1 start = 1'b1; speed = 2'd0; len = 6'd3;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(1500);
    repeat (30) @(negedge clk);
    checkOutput("clampCount", pulses.size(), 32);
    checkOutput("clampBusy", busy_o, 0);
    checkOutput("clampDoneCount", doneCount, dc + 1);

    $display("[TB] reset mid-ON at step 2");
    applyStimulus(2'd3, 6'd4);
    waitLit(6'd2, 400);
    dc = doneCount;
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstLed", led_o, 0);
    checkOutput("midRstBusy", busy_o, 0);
    checkOutput("midRstDone", done_o, 0);
    checkOutput("midRstStep", step_o, 0);
    checkOutput("midRstColor", color_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("postRstDone", doneCount, dc);
    checkOutput("postRstBusy", busy_o, 0);
    checkOutput("postRstLed", led_o, 0);

`ifdef GENIUS_PLAYER_ABORT_EN
    $display("[TB] abort on ON tick at step 1");
    applyStimulus(2'd3, 6'd3);
    waitLit(6'd1, 400);
    dc = doneCount;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    checkOutput("abortLed", led_o, 0);
    checkOutput("abortBusy", busy_o, 0);
    checkOutput("abortDone", done_o, 0);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abortNoDone", doneCount, dc);
    checkOutput("abortIdle", busy_o, 0);
    abort = 1'b1;
    applyStimulus(2'd3, 6'd2);
    repeat (3) @(negedge clk);
    checkOutput("abortBlocksStart", busy_o, 0);
    abort = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/genius_sequence_player.md
# genius_sequence_player

Plays the Genius colour sequence on the four game LEDs at a selectable speed, driven by the slow 1/2/3/5 Hz square waves from the upstream clock divider. On `start_i` it replays an 8-bit LFSR-generated sequence from a fixed seed for `len_i` steps, so each round repeats the previous prefix plus one new colour. It signals completion with a one-cycle `done_o` pulse to the game controller.

## Interface
- `MAX_LEN`, 32: maximum playable steps. `len_i` values above this are clamped.
- `SEED`, 8'hA5: LFSR load value at every start. Must be non-zero.
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `clk_1_i`, `clk_2_i`, `clk_3_i`, `clk_5_i`  in  1 each  divided square waves from the clock divider; asynchronous to this block's sampling
- `speed_i`  in  2  speed select: 0=1 Hz, 1=2 Hz, 2=3 Hz, 3=5 Hz; latched at start
- `start_i`  in  1  start request; honoured only in IDLE
- `len_i`  in  6  steps to play; latched at start
- `busy_o`  out  1  high from the accepted start until DONE is left
- `done_o`  out  1  one-cycle completion pulse
- `led_o`  out  4  one-hot LED drive; all zero when dark
- `step_o`  out  6  steps already completed in the current play
- `color_o`  out  2  colour of the current or last step

## Operation
- **Reset:**
  - All outputs are 0.
  - State is IDLE, LFSR = `SEED`, and the sync/edge flops are 0.
- **Tick generation:**
  - The selected divided clock passes through a 2-flop synchroniser and then an edge register.
  - A tick is one `clk_i` cycle asserted on every transition, rising or falling, of the synchronised signal. A tick therefore occurs once per half-period.
- **LFSR:** 8-bit Fibonacci. Next value = {q[6:0], q[7]^q[5]^q[4]^q[3]}. Colour = q[1:0]. LED = 1 << colour.
- **FSM:**
  - IDLE: on `start_i`:
    - Latch `speed_i`.
    - Set len = min(`len_i`, `MAX_LEN`).
    - LFSR = `SEED`, step = 0.
    - If len == 0, go to DONE; otherwise go to ALIGN.
  - ALIGN: wait for the first tick, then go to ON. This discards the partial half-period.
  - ON: `led_o` = one-hot of the colour. On a tick, go to OFF.
  - OFF: `led_o` = 0. On entry, step increments and the LFSR advances. On a tick, go to DONE if step == len, otherwise go to ON.
  - DONE: `done_o` = 1 for one cycle, then go to IDLE.
- **Busy:**
  - `busy_o` = 1 in ALIGN, ON, OFF and DONE.
  - `start_i` outside IDLE is ignored.
  - `speed_i` and `len_i` changes outside IDLE have no effect.
- **Reset mid-play:** outputs go low immediately, asynchronously, and no `done_o` pulse is issued.

## Timing
- All outputs are registered and update on the `clk_i` edge at which the FSM transitions.
- Divided-clock transition to tick: 3 `clk_i` cycles (2 sync flops plus edge register). The LED changes on the edge that consumes the tick.
- Each step lasts two half-periods: LED on for one half-period, then off for one.
- Start to first LED-on: 1 cycle into ALIGN, plus the wait for the first tick.
- After the last OFF tick: `done_o` high for exactly 1 cycle, then `busy_o` falls on the next cycle.
- `len_i` = 0: `done_o` pulses 1 cycle after start, and no LED is lit.

## Configuration
- **`GENIUS_PLAYER_ABORT_EN` defined:**
  - Adds input `abort_i` (1 bit).
  - When `abort_i` is high in ALIGN, ON, OFF or DONE, the next edge forces IDLE, `led_o` = 0 and `busy_o` = 0, with no `done_o` pulse.
  - Abort has priority over a simultaneous tick.
  - In IDLE, abort has priority over `start_i`.
- **Undefined:** the port is absent and play always runs to completion.

## Test plan
- Reset asserted mid-ON at step 2 -> `led_o`, `busy_o`, `done_o`, `step_o` and `color_o` all 0 in the same cycle. After release, the FSM is in IDLE and no done pulse occurs.
- `speed_i`=3, `len_i`=4, divider in simulation scale (clk_5 toggling every 10 cycles) -> `led_o` sequence 0010, 0100, 0010, 0100. Each LED is on 10 cycles and off 10 cycles, followed by exactly one `done_o` pulse.
- Start with `len_i`=1, then again with `len_i`=2 -> the second play's first colour equals the first play's colour, confirming seed reload.
- `len_i`=0 -> `done_o` 1 cycle after start, `led_o` stays 0, `busy_o` high for exactly 1 cycle.
- `len_i`=40 with `MAX_LEN`=32 -> exactly 32 LED pulses, `step_o` reaches 32. A `start_i` pulse issued during play is ignored.
- With `GENIUS_PLAYER_ABORT_EN`: `abort_i` asserted in the same cycle as an ON tick at step 1 -> IDLE on the next edge, LEDs 0, no done pulse.
